unidade_controle_desafio: RTL and testbench
===========================================

# unidade_controle_desafio

Control unit (FSM) that sequences the memory-game datapath for the challenge variant: it runs each round by walking the address counter through the stored sequence, checks every player move, and at the end of a correctly played round captures one new move from the player and writes it into memory before advancing the round counter. It sits between the top-level `iniciar`/`botoes` edge-detect logic and the datapath counters, register, comparator and RAM. It also owns the per-move timeout counter.

## Interface
- `TIMEOUT_CICLOS`, 5000: clock cycles allowed per move (5 s at 1 kHz). Must be ≥ 2.
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; forces `inicial` and clears the timeout counter.
- `iniciar` in 1: start/restart request, level-sampled.
- `jogada` in 1: one-cycle pulse from the button edge detector (`tem_jogada`).
- `igual` in 1: comparator result, registered move == memory[E].
- `fimE` in 1: address counter E == round counter R.
- `fimR` in 1: round counter R == 15.
- `zeraE`, `contaE` out 1: clear/increment the address counter.
- `zeraR`, `contaR` out 1: clear/increment the round counter.
- `registraR` out 1: load `botoes` into the move register.
- `escreveM` out 1: RAM write enable (data = move register, address = E).
- `pronto`, `ganhou`, `perdeu` out 1: game-over status.
- `db_timeout` out 1: timeout flag.
- `db_estado` out 4: current state code.

## Operation
- Moore FSM. All outputs decode from the state only; they are 0 unless listed for a state.
- State codes, outputs and transitions:
  - 0x0 `inicial`: none. `iniciar` → `preparacao`.
  - 0x1 `preparacao`: `zeraE`, `zeraR`. Unconditionally → `inicio_rodada`.
  - 0x2 `inicio_rodada`: `zeraE`. Unconditionally → `espera_jogada`.
  - 0x3 `espera_jogada`: none. `jogada` → `registra`; timeout → `fim_timeout`.
  - 0x4 `registra`: `registraR`. Unconditionally → `comparacao`.
  - 0x5 `comparacao`: none.
    - `!igual` → `fim_errou`.
    - `igual & fimE & fimR` → `fim_acertou`.
    - `igual & fimE & !fimR` → `espera_nova`.
    - Otherwise → `proximo`.
  - 0x6 `proximo`: `contaE`. Unconditionally → `espera_jogada`.
  - 0x7 `espera_nova`: none. `jogada` → `registra_nova`; timeout → `fim_timeout`.
  - 0x8 `registra_nova`: `registraR`, `contaE` (E becomes R+1). Unconditionally → `escreve`.
  - 0x9 `escreve`: `escreveM`. Unconditionally → `proxima_rodada`.
  - 0xA `proxima_rodada`: `contaR`. Unconditionally → `inicio_rodada`.
  - 0xB `fim_acertou`: `pronto`, `ganhou`.
  - 0xD `fim_timeout`: `pronto`, `perdeu`, `db_timeout`.
  - 0xE `fim_errou`: `pronto`, `perdeu`.
  - From 0xB, 0xD and 0xE: `iniciar` → `preparacao`; otherwise hold the state.
- Unused codes (0xC, 0xF) → `inicial` on the next clock.
- `iniciar` is ignored in every state except `inicial` and the three final states.
- `jogada` is ignored outside `espera_jogada` and `espera_nova`.
- Timeout counter:
  - Width $clog2(TIMEOUT_CICLOS).
  - Increments on each cycle spent in 0x3 or 0x7; cleared in every other state.
  - Timeout condition: counter == TIMEOUT_CICLOS-1 while in 0x3 or 0x7.
  - If `jogada` and timeout occur in the same cycle, `jogada` wins.
- A fully won game is 16 rounds with 15 new moves written (addresses 1..15).

## Timing
- Reset: state 0x0, every output 0, `db_estado` = 0x0 on the first clock edge with `reset`=1. `reset` mid-game aborts immediately; RAM contents are untouched.
- Latency from a `jogada` pulse to the comparison decision: 2 cycles (`registra`, then `comparacao`).
- `registraR` asserts for exactly one cycle per accepted move.
- `escreveM` asserts exactly one cycle after the `contaE` that selects the write address.
- A full timeout occurs TIMEOUT_CICLOS cycles after entering a wait state; `db_timeout` asserts on the following edge.
- Restart from a final state with `iniciar` is identical to the initial start: memory is not reinitialized. The datapath owns the ROM init file.

## Configuration
- `TIMEOUT_EN` defined:
  - Timeout counter and the `fim_timeout` path are present, as described above.
- `TIMEOUT_EN` undefined:
  - No timeout counter is built; wait states hold indefinitely.
  - `db_timeout` is constant 0 and state 0xD is unreachable. If 0xD is entered, it recovers to `inicial` like an unused code.

## Test plan
- `reset`=1 for 1 cycle mid-round (state 0x3) → next edge `db_estado`=0x0, all outputs 0; `iniciar` then yields a 0x1→0x2→0x3 sequence with `zeraE`=`zeraR`=1 in 0x1.
- Round 0: `jogada` with `igual`=1, `fimE`=1, `fimR`=0 → states 0x4, 0x5, 0x7. Then a new `jogada` gives 0x8 (`registraR`=`contaE`=1), 0x9 (`escreveM`=1), 0xA (`contaR`=1), 0x2.
- Round 2, second move with `igual`=0 → 0xE; `perdeu`=`pronto`=1, `ganhou`=0; state held until `iniciar`=1, then 0x1.
- TIMEOUT_CICLOS=20, no `jogada` in 0x3 → after 20 cycles state 0xD, `db_timeout`=`perdeu`=1. Repeat in 0x7 with the same result. `jogada` arriving on exactly the 20th cycle → 0x4, not 0xD.
- Full game with a behavioural datapath model: 16 rounds all correct, 15 writes → ends in 0xB with `ganhou`=1, after exactly 15 `escreveM` and 15 `contaR` pulses.
- With `TIMEOUT_EN` undefined: hold 0x3 for 10×TIMEOUT_CICLOS cycles → state stays 0x3 and `db_timeout`=0.

Source files
------------

// File: rtl/unidade_controle_desafio.sv
// Moore control unit for the memory-game challenge: sequences rounds, checks moves and
// appends one new move per won round. Optional per-move timeout enabled by `define TIMEOUT_EN.
module unidade_controle_desafio #(
   parameter int unsigned TIMEOUT_CICLOS = 5000
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       iniciar_i,
   input  logic       jogada_i,
   input  logic       igual_i,
   input  logic       fimE_i,
   input  logic       fimR_i,
   output logic       zeraE_o,
   output logic       contaE_o,
   output logic       zeraR_o,
   output logic       contaR_o,
   output logic       registraR_o,
   output logic       escreveM_o,
   output logic       pronto_o,
   output logic       ganhou_o,
   output logic       perdeu_o,
   output logic       db_timeout_o,
   output logic [3:0] db_estado_o
);

   typedef enum logic [3:0] {
      StInicial       = 4'h0,
      StPreparacao    = 4'h1,
      StInicioRodada  = 4'h2,
      StEsperaJogada  = 4'h3,
      StRegistra      = 4'h4,
      StComparacao    = 4'h5,
      StProximo       = 4'h6,
      StEsperaNova    = 4'h7,
      StRegistraNova  = 4'h8,
      StEscreve       = 4'h9,
      StProximaRodada = 4'hA,
      StFimAcertou    = 4'hB,
      StFimTimeout    = 4'hD,
      StFimErrou      = 4'hE
   } state_e;

   state_e state_q, state_d;
   logic   timeout;

   if (TIMEOUT_CICLOS < 2) begin : g_param_check
      $fatal(1, "TIMEOUT_CICLOS must be at least 2");
   end

`ifdef TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CICLOS);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CICLOS - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            em_espera;

   assign em_espera = (state_q == StEsperaJogada) || (state_q == StEsperaNova);
   assign cnt_d     = em_espera ? cnt_q + 1'b1 : '0;
   assign timeout   = em_espera && (cnt_q == CntMax);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= StInicial;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      zeraE_o      = 1'b0;
      contaE_o     = 1'b0;
      zeraR_o      = 1'b0;
      contaR_o     = 1'b0;
      registraR_o  = 1'b0;
      escreveM_o   = 1'b0;
      pronto_o     = 1'b0;
      ganhou_o     = 1'b0;
      perdeu_o     = 1'b0;
      db_timeout_o = 1'b0;

      case (state_q)
         StInicial: begin
            if (iniciar_i) state_d = StPreparacao;
         end
         StPreparacao: begin
            zeraE_o = 1'b1;
            zeraR_o = 1'b1;
            state_d = StInicioRodada;
         end
         StInicioRodada: begin
            zeraE_o = 1'b1;
            state_d = StEsperaJogada;
         end
         // A move arriving on the timeout cycle takes priority.
         StEsperaJogada: begin
            if (jogada_i)     state_d = StRegistra;
            else if (timeout) state_d = StFimTimeout;
         end
         StRegistra: begin
            registraR_o = 1'b1;
            state_d     = StComparacao;
         end
         StComparacao: begin
            if (!igual_i)     state_d = StFimErrou;
            else if (!fimE_i) state_d = StProximo;
            else if (fimR_i)  state_d = StFimAcertou;
            else              state_d = StEsperaNova;
         end
         StProximo: begin
            contaE_o = 1'b1;
            state_d  = StEsperaJogada;
         end
         StEsperaNova: begin
            if (jogada_i)     state_d = StRegistraNova;
            else if (timeout) state_d = StFimTimeout;
         end
         // Advancing E here points it at R+1, the slot the new move is written to.
         StRegistraNova: begin
            registraR_o = 1'b1;
            contaE_o    = 1'b1;
            state_d     = StEscreve;
         end
         StEscreve: begin
            escreveM_o = 1'b1;
            state_d    = StProximaRodada;
         end
         StProximaRodada: begin
            contaR_o = 1'b1;
            state_d  = StInicioRodada;
         end
         StFimAcertou: begin
            pronto_o = 1'b1;
            ganhou_o = 1'b1;
            if (iniciar_i) state_d = StPreparacao;
         end
`ifdef TIMEOUT_EN
         StFimTimeout: begin
            pronto_o     = 1'b1;
            perdeu_o     = 1'b1;
            db_timeout_o = 1'b1;
            if (iniciar_i) state_d = StPreparacao;
         end
`endif
         StFimErrou: begin
            pronto_o = 1'b1;
            perdeu_o = 1'b1;
            if (iniciar_i) state_d = StPreparacao;
         end
         default: begin
            state_d = StInicial;
         end
      endcase
   end

   assign db_estado_o = state_q;

endmodule

// File: tb/tb_unidade_controle_desafio.sv
// Self-checking bench for unidade_controle_desafio: directed state walks plus random full
// games played against a behavioural datapath (counters, move register, RAM).
module tb_unidade_controle_desafio;

   localparam int unsigned T = 20;

   // Output vector bit order: zeraE contaE zeraR contaR registraR escreveM pronto ganhou
   // perdeu db_timeout.
   localparam logic [9:0] O_NONE = 10'b0000000000;
   localparam logic [9:0] O_PREP = 10'b1010000000;
   localparam logic [9:0] O_INI  = 10'b1000000000;
   localparam logic [9:0] O_REG  = 10'b0000100000;
   localparam logic [9:0] O_PROX = 10'b0100000000;
   localparam logic [9:0] O_REGN = 10'b0100100000;
   localparam logic [9:0] O_ESC  = 10'b0000010000;
   localparam logic [9:0] O_PRXR = 10'b0001000000;
   localparam logic [9:0] O_WIN  = 10'b0000001100;
   localparam logic [9:0] O_ERR  = 10'b0000001010;
`ifdef TIMEOUT_EN
   localparam logic [9:0] O_TO   = 10'b0000001011;
`endif

   logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, jogada = 1'b0;
   logic igual_d = 1'b0, fimE_d = 1'b0, fimR_d = 1'b0, use_model = 1'b0;
   logic igual, fimE, fimR;
   logic zeraE, contaE, zeraR, contaR, registraR, escreveM, pronto, ganhou, perdeu, db_timeout;
   logic [3:0] db_estado;
   logic [9:0] outs;

   logic [3:0] botoes = 4'd0;
   logic [3:0] mem [16];
   logic [3:0] rom [16];
   logic [3:0] e_q = 4'd0, r_q = 4'd0, mv_q = 4'd0;
   logic load_mem = 1'b0, clr_cnt = 1'b0;
   int n_esc = 0, n_cr = 0;
   int total = 0, bad = 0;
   logic [3:0] seq [$];

   always #5 clock = ~clock;

   unidade_controle_desafio #(.TIMEOUT_CICLOS(T)) dut (
      .clock_i(clock), .reset_i(reset), .iniciar_i(iniciar), .jogada_i(jogada),
      .igual_i(igual), .fimE_i(fimE), .fimR_i(fimR),
      .zeraE_o(zeraE), .contaE_o(contaE), .zeraR_o(zeraR), .contaR_o(contaR),
      .registraR_o(registraR), .escreveM_o(escreveM), .pronto_o(pronto),
      .ganhou_o(ganhou), .perdeu_o(perdeu), .db_timeout_o(db_timeout),
      .db_estado_o(db_estado)
   );

   assign outs  = {zeraE, contaE, zeraR, contaR, registraR, escreveM, pronto, ganhou, perdeu,
                   db_timeout};
   assign igual = use_model ? (mv_q == mem[e_q]) : igual_d;
   assign fimE  = use_model ? (e_q == r_q) : fimE_d;
   assign fimR  = use_model ? (r_q == 4'd15) : fimR_d;

   // Behavioural datapath driven by the control outputs.
   always @(posedge clock) begin
      if (load_mem) begin
         for (int i = 0; i < 16; i++) mem[i] <= rom[i];
      end else if (escreveM) begin
         mem[e_q] <= mv_q;
      end
      if (zeraE) e_q <= 4'd0;
      else if (contaE) e_q <= e_q + 4'd1;
      if (zeraR) r_q <= 4'd0;
      else if (contaR) r_q <= r_q + 4'd1;
      if (registraR) mv_q <= botoes;
      if (clr_cnt) begin
         n_esc <= 0;
         n_cr  <= 0;
      end else begin
         if (escreveM) n_esc <= n_esc + 1;
         if (contaR) n_cr <= n_cr + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic restart();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      tick();
   endtask

   task automatic pulse_jogada();
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
   endtask

   task automatic play_move(input logic [3:0] v, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (db_estado == 4'h3 || db_estado == 4'h7) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         botoes = v;
         pulse_jogada();
      end
   endtask

   task automatic test_reset();
      use_model = 1'b0;
      reset = 1'b1;
      tick();
      total++; if ({db_estado, outs} !== {4'h0, O_NONE}) begin bad++;
         $display("FAIL reset_first got=%h want=%h", {db_estado, outs}, {4'h0, O_NONE}); end
      reset = 1'b0;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      total++; if ({db_estado, outs} !== {4'h1, O_PREP}) begin bad++;
         $display("FAIL start_prep got=%h want=%h", {db_estado, outs}, {4'h1, O_PREP}); end
      tick();
      total++; if ({db_estado, outs} !== {4'h2, O_INI}) begin bad++;
         $display("FAIL start_ini got=%h want=%h", {db_estado, outs}, {4'h2, O_INI}); end
      tick();
      total++; if ({db_estado, outs} !== {4'h3, O_NONE}) begin bad++;
         $display("FAIL start_wait got=%h want=%h", {db_estado, outs}, {4'h3, O_NONE}); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if ({db_estado, outs} !== {4'h0, O_NONE}) begin bad++;
         $display("FAIL reset_midround got=%h want=%h", {db_estado, outs}, {4'h0, O_NONE}); end
      pulse_jogada();
      total++; if (db_estado !== 4'h0) begin bad++;
         $display("FAIL jogada_in_inicial got=%h want=0", db_estado); end
   endtask

   task automatic test_round0();
      restart();
      igual_d = 1'b1; fimE_d = 1'b1; fimR_d = 1'b0;
      pulse_jogada();
      total++; if ({db_estado, outs} !== {4'h4, O_REG}) begin bad++;
         $display("FAIL r0_registra got=%h want=%h", {db_estado, outs}, {4'h4, O_REG}); end
      tick();
      total++; if ({db_estado, outs} !== {4'h5, O_NONE}) begin bad++;
         $display("FAIL r0_compara got=%h want=%h", {db_estado, outs}, {4'h5, O_NONE}); end
      tick();
      total++; if ({db_estado, outs} !== {4'h7, O_NONE}) begin bad++;
         $display("FAIL r0_espera_nova got=%h want=%h", {db_estado, outs}, {4'h7, O_NONE}); end
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      total++; if (db_estado !== 4'h7) begin bad++;
         $display("FAIL r0_iniciar_ignored got=%h want=7", db_estado); end
      pulse_jogada();
      total++; if ({db_estado, outs} !== {4'h8, O_REGN}) begin bad++;
         $display("FAIL r0_registra_nova got=%h want=%h", {db_estado, outs}, {4'h8, O_REGN}); end
      tick();
      total++; if ({db_estado, outs} !== {4'h9, O_ESC}) begin bad++;
         $display("FAIL r0_escreve got=%h want=%h", {db_estado, outs}, {4'h9, O_ESC}); end
      tick();
      total++; if ({db_estado, outs} !== {4'hA, O_PRXR}) begin bad++;
         $display("FAIL r0_prox_rodada got=%h want=%h", {db_estado, outs}, {4'hA, O_PRXR}); end
      tick();
      total++; if ({db_estado, outs} !== {4'h2, O_INI}) begin bad++;
         $display("FAIL r0_inicio_rodada got=%h want=%h", {db_estado, outs}, {4'h2, O_INI}); end
   endtask

   task automatic test_erro();
      bit left;
      restart();
      igual_d = 1'b1; fimE_d = 1'b0; fimR_d = 1'b0;
      pulse_jogada();
      tick();
      tick();
      total++; if ({db_estado, outs} !== {4'h6, O_PROX}) begin bad++;
         $display("FAIL er_proximo got=%h want=%h", {db_estado, outs}, {4'h6, O_PROX}); end
      tick();
      igual_d = 1'b0;
      pulse_jogada();
      tick();
      tick();
      total++; if ({db_estado, outs} !== {4'hE, O_ERR}) begin bad++;
         $display("FAIL er_fim_errou got=%h want=%h", {db_estado, outs}, {4'hE, O_ERR}); end
      left = 1'b0;
      for (int k = 0; k < 8; k++) begin
         jogada = 1'($urandom);
         igual_d = 1'($urandom);
         tick();
         if (db_estado !== 4'hE) left = 1'b1;
      end
      jogada = 1'b0;
      total++; if (left !== 1'b0) begin bad++;
         $display("FAIL er_hold got_left=%0b want=0", left); end
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      total++; if ({db_estado, outs} !== {4'h1, O_PREP}) begin bad++;
         $display("FAIL er_restart got=%h want=%h", {db_estado, outs}, {4'h1, O_PREP}); end
   endtask

`ifdef TIMEOUT_EN
   task automatic test_timeout();
      bit left;
      restart();
      left = 1'b0;
      for (int k = 0; k < int'(T) - 1; k++) begin
         tick();
         if (db_estado !== 4'h3) left = 1'b1;
      end
      total++; if (left !== 1'b0) begin bad++; $display("FAIL to_early3 left=%0b want=0", left); end
      tick();
      total++; if ({db_estado, outs} !== {4'hD, O_TO}) begin bad++;
         $display("FAIL to_wait3 got=%h want=%h", {db_estado, outs}, {4'hD, O_TO}); end
      restart();
      igual_d = 1'b1; fimE_d = 1'b1; fimR_d = 1'b0;
      pulse_jogada();
      tick();
      tick();
      left = 1'b0;
      for (int k = 0; k < int'(T) - 1; k++) begin
         tick();
         if (db_estado !== 4'h7) left = 1'b1;
      end
      total++; if (left !== 1'b0) begin bad++; $display("FAIL to_early7 left=%0b want=0", left); end
      tick();
      total++; if ({db_estado, outs} !== {4'hD, O_TO}) begin bad++;
         $display("FAIL to_wait7 got=%h want=%h", {db_estado, outs}, {4'hD, O_TO}); end
      restart();
      for (int k = 0; k < int'(T) - 1; k++) tick();
      pulse_jogada();
      total++; if ({db_estado, outs} !== {4'h4, O_REG}) begin bad++;
         $display("FAIL to_jogada_wins got=%h want=%h", {db_estado, outs}, {4'h4, O_REG}); end
   endtask
`else
   task automatic test_hold();
      bit left;
      restart();
      left = 1'b0;
      for (int k = 0; k < 10 * int'(T); k++) begin
         tick();
         if (db_estado !== 4'h3 || db_timeout !== 1'b0) left = 1'b1;
      end
      total++; if (left !== 1'b0 || db_estado !== 4'h3) begin bad++;
         $display("FAIL hold_no_timeout got=%h left=%0b want=3", db_estado, left); end
   endtask
`endif

   task automatic game_setup();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
      load_mem = 1'b1;
      clr_cnt = 1'b1;
      tick();
      load_mem = 1'b0;
      clr_cnt = 1'b0;
      use_model = 1'b1;
      seq.delete();
      seq.push_back(rom[0]);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s);
      for (int k = 0; k < 10; k++) begin
         if (db_estado == s) break;
         tick();
      end
   endtask

   task automatic test_full_game();
      int stalls, wrong;
      bit ok;
      logic [3:0] nm;
      game_setup();
      stalls = 0;
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i <= r; i++) begin
            play_move(seq[i], ok);
            if (!ok) stalls++;
         end
         if (r < 15) begin
            nm = 4'($urandom);
            play_move(nm, ok);
            if (!ok) stalls++;
            seq.push_back(nm);
         end
      end
      wait_state(4'hB);
      total++; if (stalls != 0) begin bad++; $display("FAIL game_stalls got=%0d want=0", stalls); end
      total++; if ({db_estado, outs} !== {4'hB, O_WIN}) begin bad++;
         $display("FAIL game_won got=%h want=%h", {db_estado, outs}, {4'hB, O_WIN}); end
      total++; if (n_esc != 15 || n_cr != 15) begin bad++;
         $display("FAIL game_pulses got esc=%0d contaR=%0d want 15/15", n_esc, n_cr); end
      wrong = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== seq[i]) wrong++;
      total++; if (wrong != 0) begin bad++; $display("FAIL game_mem bad_words=%0d want=0", wrong); end
   endtask

   task automatic test_lose();
      int rr, pos, stalls;
      bit ok;
      logic [3:0] nm;
      game_setup();
      rr = $urandom_range(1, 4);
      pos = $urandom_range(0, rr);
      stalls = 0;
      for (int r = 0; r < rr; r++) begin
         for (int i = 0; i <= r; i++) begin
            play_move(seq[i], ok);
            if (!ok) stalls++;
         end
         nm = 4'($urandom);
         play_move(nm, ok);
         if (!ok) stalls++;
         seq.push_back(nm);
      end
      for (int i = 0; i < pos; i++) begin
         play_move(seq[i], ok);
         if (!ok) stalls++;
      end
      play_move(seq[pos] ^ 4'h1, ok);
      if (!ok) stalls++;
      wait_state(4'hE);
      total++; if (stalls != 0 || {db_estado, outs} !== {4'hE, O_ERR}) begin bad++;
         $display("FAIL lose_state got=%h stalls=%0d want=%h", {db_estado, outs}, stalls,
                  {4'hE, O_ERR}); end
      total++; if (n_esc != rr) begin bad++; $display("FAIL lose_writes got=%0d want=%0d", n_esc, rr);
      end
   endtask

   initial begin
      test_reset();
      test_round0();
      test_erro();
`ifdef TIMEOUT_EN
      test_timeout();
`else
      test_hold();
`endif
      test_full_game();
      for (int g = 0; g < 3; g++) test_lose();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
